axi4_write_arbiter: RTL
=======================

Name: axi4_write_arbiter

Overview:
- Round-robin arbiter sharing one AXI4 master write path (AW, W, B) between NUM_MASTERS requesters.
- Sits between local AXI4 initiators and the single AXI4 signal interface watched by the AXI4 monitor.
- W beats follow AW grant order through an order FIFO.
- B responses are routed back using master-index bits prepended to AWID.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
ADDR_WIDTH, 32, AWADDR width
WDATA_WIDTH, 32, WDATA width; WSTRB is WDATA_WIDTH/8
ID_WIDTH, 4, requester-side ID width; master-side ID is ID_WIDTH+MW, where MW = $clog2(NUM_MASTERS)
ORDER_DEPTH, 4, order FIFO depth (power of 2), i.e. maximum accepted AW bursts awaiting W completion

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
s_awvalid  in  NUM_MASTERS  per-requester AWVALID
s_awready  out  NUM_MASTERS  per-requester AWREADY
s_awaddr  in  NUM_MASTERS*ADDR_WIDTH  packed AWADDR
s_awlen  in  NUM_MASTERS*8  packed AWLEN
s_awsize  in  NUM_MASTERS*3  packed AWSIZE
s_awburst  in  NUM_MASTERS*2  packed AWBURST
s_awid  in  NUM_MASTERS*ID_WIDTH  packed AWID
s_wvalid  in  NUM_MASTERS  WVALID
s_wready  out  NUM_MASTERS  WREADY
s_wdata  in  NUM_MASTERS*WDATA_WIDTH  packed WDATA
s_wstrb  in  NUM_MASTERS*WDATA_WIDTH/8  packed WSTRB
s_wlast  in  NUM_MASTERS  WLAST
s_bvalid  out  NUM_MASTERS  BVALID
s_bready  in  NUM_MASTERS  BREADY
s_bid  out  ID_WIDTH  BID, common to all requesters
s_bresp  out  2  BRESP, common to all requesters
m_awvalid/m_awready  out/in  1/1  master AW handshake
m_awaddr, m_awlen, m_awsize, m_awburst  out  ADDR_WIDTH/8/3/2  master AW payload
m_awid  out  ID_WIDTH+MW  {grant index, requester AWID}
m_wvalid/m_wready  out/in  1/1  master W handshake
m_wdata, m_wstrb, m_wlast  out  WDATA_WIDTH/WDATA_WIDTH/8/1  master W payload
m_bvalid/m_bready  in/out  1/1  master B handshake
m_bid  in  ID_WIDTH+MW  master BID
m_bresp  in  2  master BRESP

Behaviour:
- Reset (sync, ARESET=1 at a rising ACLK):
  - state=IDLE, rr pointer=0, order FIFO empty.
  - m_awvalid=0, all s_awready=0, m_aw* payload=0.
  - Any in-flight AW or W burst is abandoned; no partial state survives reset.
- AW FSM, IDLE:
  - If any s_awvalid and FIFO count<ORDER_DEPTH, pick the first asserted index at or after the rr pointer (wrapping).
  - Register the grant index and payload; go to AW_HOLD.
- AW FSM, AW_HOLD:
  - m_awvalid=1 and payload come from registers; they are stable while held.
  - s_awready[grant] = m_awready; all other s_awready=0.
  - On m_awready: push grant index into FIFO, rr pointer = grant+1 (mod NUM_MASTERS), return to IDLE.
- AW latency: s_awvalid to m_awvalid is 1 cycle; peak AW throughput is 1 per 2 cycles.
- Full FIFO: no grant is issued and all requesters stall. A push is never attempted when full.
- W path (combinational from FIFO head h):
  - FIFO non-empty: m_wvalid = s_wvalid[h]; m_w* = requester h; s_wready[h] = m_wready; all other s_wready=0.
  - FIFO empty: m_wvalid=0 and all s_wready=0. W data offered before its AW is accepted stalls.
  - Handshake with m_wlast=1 pops the FIFO.
  - Same-cycle push and pop are both honoured; count is unchanged.
- B path (combinational):
  - sel = m_bid[ID_WIDTH+MW-1:ID_WIDTH].
  - s_bvalid[i] = m_bvalid && sel==i.
  - m_bready = s_bready[sel].
  - s_bid = m_bid[ID_WIDTH-1:0]; s_bresp = m_bresp.
  - sel >= NUM_MASTERS: m_bready=1 and the response is dropped.
- The arbiter does not check WLAST count against AWLEN; WLAST alone terminates a burst.

Test Plan:
- Single requester 0, AWADDR=0x100, AWLEN=3, ID=0x5 -> m_awvalid 1 cycle after s_awvalid, m_awid=0x05, 4 W beats pass through, FIFO pops on beat 4, B with m_bid=0x05 gives s_bvalid[0], s_bid=0x5.
- Requesters 0,1,2 assert AWVALID together, m_awready=1 -> grant order 0,1,2; then requester 0 re-asserts with 3 -> grant 3 before 0.
- ORDER_DEPTH=4, five AW bursts with W held off -> 4 accepted, 5th stalls with s_awready=0 until the first WLAST handshake, then it is granted.
- Requester 1 drives W before its AW is granted -> s_wready[1]=0 and m_wvalid=0 until its AW handshake completes.
- m_bid=0x2A with NUM_MASTERS=4, ID_WIDTH=4 -> s_bvalid[2]=1, s_bid=0xA; m_bready follows s_bready[2].
- ARESET asserted mid-burst after beat 2 of 4 -> next cycle m_awvalid=0, all s_wready=0, FIFO empty; a new AW is granted normally after reset deasserts.

Source files
------------

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter that shares one AXI4 write path (AW, W, B) between
// NUM_MASTERS requesters. AW grants are queued in an order FIFO so W beats
// follow grant order. B responses are routed back using the master-index
// bits that the arbiter prepends to AWID.
module axi4_write_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int WDATA_WIDTH = 32,
    parameter int ID_WIDTH    = 4,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                                       ACLK,
    input  logic                                       ARESET,
    input  logic [NUM_MASTERS-1:0]                     s_awvalid,
    output logic [NUM_MASTERS-1:0]                     s_awready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [NUM_MASTERS*8-1:0]                   s_awlen,
    input  logic [NUM_MASTERS*3-1:0]                   s_awsize,
    input  logic [NUM_MASTERS*2-1:0]                   s_awburst,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]            s_awid,
    input  logic [NUM_MASTERS-1:0]                     s_wvalid,
    output logic [NUM_MASTERS-1:0]                     s_wready,
    input  logic [NUM_MASTERS*WDATA_WIDTH-1:0]         s_wdata,
    input  logic [NUM_MASTERS*WDATA_WIDTH/8-1:0]       s_wstrb,
    input  logic [NUM_MASTERS-1:0]                     s_wlast,
    output logic [NUM_MASTERS-1:0]                     s_bvalid,
    input  logic [NUM_MASTERS-1:0]                     s_bready,
    output logic [ID_WIDTH-1:0]                        s_bid,
    output logic [1:0]                                 s_bresp,
    output logic                                       m_awvalid,
    input  logic                                       m_awready,
    output logic [ADDR_WIDTH-1:0]                      m_awaddr,
    output logic [7:0]                                 m_awlen,
    output logic [2:0]                                 m_awsize,
    output logic [1:0]                                 m_awburst,
    output logic [ID_WIDTH+$clog2(NUM_MASTERS)-1:0]    m_awid,
    output logic                                       m_wvalid,
    input  logic                                       m_wready,
    output logic [WDATA_WIDTH-1:0]                     m_wdata,
    output logic [WDATA_WIDTH/8-1:0]                   m_wstrb,
    output logic                                       m_wlast,
    input  logic                                       m_bvalid,
    output logic                                       m_bready,
    input  logic [ID_WIDTH+$clog2(NUM_MASTERS)-1:0]    m_bid,
    input  logic [1:0]                                 m_bresp
);

    localparam int MW   = $clog2(NUM_MASTERS);
    localparam int MIDW = ID_WIDTH + MW;
    localparam int SW   = WDATA_WIDTH / 8;
    localparam int PW   = $clog2(ORDER_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        AW_HOLD = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    grant_load_s;
    logic                    pick_found_s;
    logic [MW-1:0]           pick_idx_s;
    logic [MW-1:0]           cand_s;
    logic [MW-1:0]           rr_ptr_r;
    logic [MW-1:0]           grant_r;
    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [7:0]              awlen_r;
    logic [2:0]              awsize_r;
    logic [1:0]              awburst_r;
    logic [MIDW-1:0]         awid_r;

    logic [MW-1:0]           fifo_mem_r [ORDER_DEPTH];
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [MW-1:0]           head_s;
    logic                    aw_hs_s;
    logic                    w_last_hs_s;
    logic [MW-1:0]           b_sel_s;

    // Per-requester unpacked views of the packed request buses
    logic [ADDR_WIDTH-1:0]   awaddr_a_s  [NUM_MASTERS];
    logic [7:0]              awlen_a_s   [NUM_MASTERS];
    logic [2:0]              awsize_a_s  [NUM_MASTERS];
    logic [1:0]              awburst_a_s [NUM_MASTERS];
    logic [ID_WIDTH-1:0]     awid_a_s    [NUM_MASTERS];
    logic [WDATA_WIDTH-1:0]  wdata_a_s   [NUM_MASTERS];
    logic [SW-1:0]           wstrb_a_s   [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign awaddr_a_s[g]  = s_awaddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign awlen_a_s[g]   = s_awlen[g*8 +: 8];
        assign awsize_a_s[g]  = s_awsize[g*3 +: 3];
        assign awburst_a_s[g] = s_awburst[g*2 +: 2];
        assign awid_a_s[g]    = s_awid[g*ID_WIDTH +: ID_WIDTH];
        assign wdata_a_s[g]   = s_wdata[g*WDATA_WIDTH +: WDATA_WIDTH];
        assign wstrb_a_s[g]   = s_wstrb[g*SW +: SW];
    end

    assign fifo_full_s  = (count_r == CW'(ORDER_DEPTH));
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign aw_hs_s      = (state_r == AW_HOLD) && m_awready;
    assign w_last_hs_s  = !fifo_empty_s && m_wvalid && m_wready && m_wlast;
    assign b_sel_s      = m_bid[MIDW-1:ID_WIDTH];

    // Master AW channel is driven straight from the held grant registers
    assign m_awvalid = (state_r == AW_HOLD);
    assign m_awaddr  = awaddr_r;
    assign m_awlen   = awlen_r;
    assign m_awsize  = awsize_r;
    assign m_awburst = awburst_r;
    assign m_awid    = awid_r;

    // Round-robin search: first asserted AWVALID at or after the rr pointer
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {MW{1'b0}};
        cand_s       = {MW{1'b0}};
        for (int off = 0; off < NUM_MASTERS; off++) begin
            if (int'(rr_ptr_r) + off >= NUM_MASTERS) begin
                cand_s = MW'(int'(rr_ptr_r) + off - NUM_MASTERS);
            end else begin
                cand_s = MW'(int'(rr_ptr_r) + off);
            end
            if (!pick_found_s && s_awvalid[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // AW FSM next-state and per-requester AWREADY
    always_comb begin
        state_next_s = state_r;
        grant_load_s = 1'b0;
        s_awready    = {NUM_MASTERS{1'b0}};
        case (state_r)
            IDLE: begin
                if (pick_found_s && !fifo_full_s) begin
                    state_next_s = AW_HOLD;
                    grant_load_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            AW_HOLD: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    s_awready[i] = m_awready && (grant_r == MW'(i));
                end
                if (m_awready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = AW_HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // AW FSM state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant index, held AW payload and round-robin pointer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rr_ptr_r  <= {MW{1'b0}};
            grant_r   <= {MW{1'b0}};
            awaddr_r  <= {ADDR_WIDTH{1'b0}};
            awlen_r   <= 8'd0;
            awsize_r  <= 3'd0;
            awburst_r <= 2'd0;
            awid_r    <= {MIDW{1'b0}};
        end else if (grant_load_s) begin
            grant_r   <= pick_idx_s;
            awaddr_r  <= awaddr_a_s[pick_idx_s];
            awlen_r   <= awlen_a_s[pick_idx_s];
            awsize_r  <= awsize_a_s[pick_idx_s];
            awburst_r <= awburst_a_s[pick_idx_s];
            awid_r    <= {pick_idx_s, awid_a_s[pick_idx_s]};
        end else if (aw_hs_s) begin
            if (int'(grant_r) == NUM_MASTERS - 1) begin
                rr_ptr_r <= {MW{1'b0}};
            end else begin
                rr_ptr_r <= grant_r + MW'(1'b1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Order FIFO: push grant on AW handshake, pop on the WLAST handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < ORDER_DEPTH; i++) begin
                fifo_mem_r[i] <= {MW{1'b0}};
            end
        end else begin
            if (aw_hs_s) begin
                fifo_mem_r[wr_ptr_r] <= grant_r;
                wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
            end
            if (w_last_hs_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({aw_hs_s, w_last_hs_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // W path: steer the requester at the FIFO head onto the master W channel
    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = {WDATA_WIDTH{1'b0}};
        m_wstrb  = {SW{1'b0}};
        m_wlast  = 1'b0;
        s_wready = {NUM_MASTERS{1'b0}};
        if (!fifo_empty_s) begin
            m_wvalid = s_wvalid[head_s];
            m_wdata  = wdata_a_s[head_s];
            m_wstrb  = wstrb_a_s[head_s];
            m_wlast  = s_wlast[head_s];
            for (int i = 0; i < NUM_MASTERS; i++) begin
                s_wready[i] = m_wready && (head_s == MW'(i));
            end
        end else begin
            m_wvalid = 1'b0;
        end
    end

    // B path: route by the master-index bits of BID; drop unknown indices
    always_comb begin
        s_bvalid = {NUM_MASTERS{1'b0}};
        m_bready = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_bvalid[i] = m_bvalid && (b_sel_s == MW'(i));
        end
        if (int'(b_sel_s) < NUM_MASTERS) begin
            m_bready = s_bready[b_sel_s];
        end else begin
            m_bready = 1'b1;
        end
    end

    assign s_bid   = m_bid[ID_WIDTH-1:0];
    assign s_bresp = m_bresp;

endmodule
